// File: rtl/seq_shift_pkg.sv
// Shared encodings for the iterative shifter: operation codes and FSM states.
package seq_shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/seq_shift_unit_shift_step.sv
// One iteration of the shifter: moves acc by 2^k in the op direction, or passes it through.
module shift_step
    import seq_shift_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int KW   = 3
) (
    input  logic [XLEN-1:0] acc_i,
    input  logic [KW-1:0]   k_i,
    input  logic [1:0]      op_i,
    input  logic            en_i,
    output logic [XLEN-1:0] acc_o
);

    logic [XLEN-1:0] dist_s;

    // Stage shift by a power of two; reserved op code behaves as a left shift.
    always_comb begin
        dist_s = {{(XLEN-1){1'b0}}, 1'b1} << k_i;
        acc_o  = acc_i;
        if (en_i) begin
            case (op_i)
                OP_SRL:  acc_o = acc_i >> dist_s;
                OP_SRA:  acc_o = $unsigned($signed(acc_i) >>> dist_s);
                default: acc_o = acc_i << dist_s;
            endcase
        end else begin
            acc_o = acc_i;
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Iterative EX-stage shifter: resolves one shamt bit per cycle, LSB first, with early exit.
module seq_shift_unit
    import seq_shift_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [SHW-1:0]  shamt_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] data_o
);

    localparam int KW = $clog2(SHW);

    state_e          state_q, state_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [SHW-1:0]  amt_q, amt_d;
    logic [KW-1:0]   k_q, k_d;
    logic [1:0]      op_q, op_d;
    logic [XLEN-1:0] hold_q, hold_d;
    logic [XLEN-1:0] step_s;
    logic            last_s;

    shift_step #(
        .XLEN (XLEN),
        .KW   (KW)
    ) u_step (
        .acc_i (acc_q),
        .k_i   (k_q),
        .op_i  (op_q),
        .en_i  (amt_q[0]),
        .acc_o (step_s)
    );

    // A flush in the DONE cycle must hide the pulse and keep the previous result visible,
    // so the result is shown straight from acc during DONE and captured into hold afterwards.
    assign busy_o = (state_q != IDLE);
    assign done_o = (state_q == DONE) && !flush_i;
    assign data_o = done_o ? acc_q : hold_q;
    assign last_s = (amt_q[SHW-1:1] == {(SHW-1){1'b0}});

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        amt_d   = amt_q;
        k_d     = k_q;
        op_d    = op_q;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (start_i) begin
                    acc_d   = data_i;
                    amt_d   = shamt_i;
                    op_d    = op_i;
                    k_d     = {KW{1'b0}};
                    state_d = (shamt_i != {SHW{1'b0}}) ? SHIFT : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    acc_d   = step_s;
                    amt_d   = amt_q >> 1;
                    k_d     = k_q + {{(KW-1){1'b0}}, 1'b1};
                    state_d = last_s ? DONE : SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result holding register: captures acc on every delivered done pulse.
    always_comb begin
        hold_d = hold_q;
        if (done_o) begin
            hold_d = acc_q;
        end else begin
            hold_d = hold_q;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            acc_q   <= {XLEN{1'b0}};
            amt_q   <= {SHW{1'b0}};
            k_q     <= {KW{1'b0}};
            op_q    <= 2'b00;
            hold_q  <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            amt_q   <= amt_d;
            k_q     <= k_d;
            op_q    <= op_d;
            hold_q  <= hold_d;
        end
    end

endmodule
